uarc_receiver: RTL and testbench
================================

Name: uarc_receiver

Overview:
Receiver-side endpoint for one UARC bus lane. Sits between one lane of a sender core's global/sender signals and the local core's message-intake logic. It accepts kill, incept, send and stream requests, acknowledges them, and buffers send/stream words in a small FIFO. It is the responder that closes the sender_*_ack handshake an initiating core waits on.

Parameters:
WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
FIFO_MAG, 2, log2 of FIFO depth; FIFO_DEPTH = 1 << FIFO_MAG, minimum 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; all state clears while 0.
enable  in  1  sender has selected this lane.
kill  in  1  kill request.
kill_ack  out  1  kill acknowledge pulse.
incept  in  1  incept request.
incept_ack  out  1  incept acknowledge pulse.
send  in  1  send request; the data word is valid.
send_ack  out  1  send acknowledge pulse.
stream  in  1  stream request; the data word is valid.
stream_ack  out  1  stream acknowledge pulse.
data  in  WORD_WIDTH  send/stream word.
self_permission, self_address, incept_permission, incept_address  in  WORD_WIDTH each  incept payload.
out_valid  out  1  FIFO head is valid.
out_ready  in  1  core pops the FIFO head.
out_data  out  WORD_WIDTH  FIFO head word.
out_stream  out  1  FIFO head arrived via stream (0 = send).
out_count  out  FIFO_MAG+1  number of FIFO entries.
killed  out  1  one-cycle pulse to the core when a kill is accepted.
inc_valid  out  1  incept payload is held for the core.
inc_ready  in  1  core consumes the incept payload.
inc_self_permission, inc_self_address, inc_permission, inc_address  out  WORD_WIDTH each  latched incept payload.

Behaviour:
- Reset (reset = 0, async):
  - all acks = 0, killed = 0, inc_valid = 0;
  - FIFO empty: out_valid = 0, out_count = 0;
  - payload registers = 0, ack-guard = 0.
- Ack-guard:
  - All four acks are registered outputs.
  - At most one ack is high per cycle.
  - No request is evaluated in a cycle where any ack is high. This gives the sender one cycle to drop or change its request, so one lane transfer takes a minimum of 2 cycles.
- Request priority, evaluated only when enable = 1 and the guard is clear: kill > incept > send > stream. Lower-priority requests in the same cycle are left pending and not acked.
- Kill:
  - Accepted unconditionally; kill_ack = 1 next cycle, killed = 1 next cycle.
  - Flushes the FIFO and clears inc_valid at the same edge.
  - A core pop in the same cycle is discarded.
- Incept:
  - Accepted only if inc_valid = 0. On acceptance, the 4 payload words are latched, inc_valid = 1 and incept_ack = 1, all next cycle.
  - If inc_valid = 1, the request stalls (no ack) until the core consumes.
  - inc_valid clears at the edge where inc_valid & inc_ready.
- Send / stream:
  - Accepted only if the FIFO is not full, or is full but popped this same cycle (a simultaneous push and pop is allowed; out_count is unchanged).
  - On acceptance: push {stream_flag, data}; send_ack or stream_ack = 1 next cycle.
  - When the FIFO is full and not popped: no ack; the sender holds its request.
- FIFO:
  - Circular buffer with FIFO_MAG-bit read/write pointers that wrap modulo FIFO_DEPTH.
  - out_data and out_stream come from the head combinationally; their values are don't-care when out_valid = 0.
  - out_valid = (out_count != 0).
  - A pop when empty is ignored.
  - out_count saturates neither way; its range is 0..FIFO_DEPTH.
- enable = 0:
  - No requests are evaluated.
  - Any ack already registered still completes its single pulse.
- Reset asserted mid-transfer: the pending ack is dropped and the FIFO content is lost.

Test Plan:
- Basic send: reset, release, then enable = 1, send = 1, data = 0xDEADBEEF held. Required: send_ack pulses exactly one cycle after the first sampling edge. After the sender drops send, out_valid = 1, out_data = 0xDEADBEEF, out_stream = 0, out_count = 1.
- Fill and back-pressure (FIFO_MAG = 2): push 0..3 with out_ready = 0, then hold send with data = 4. Required: 4 acks, out_count = 4, no 5th ack. One pop then yields an ack; the FIFO holds 1,2,3,4 in order.
- Priority: kill = 1, incept = 1, send = 1 in the same cycle. Required: only kill_ack and killed pulse; FIFO empty. On the next guarded-clear cycle, with kill dropped, incept_ack pulses.
- Incept stall: incept payload 0x11/0x22/0x33/0x44 accepted with inc_ready = 0, then a second incept is requested. Required: no second ack until inc_ready = 1 for one cycle. The second payload is then latched.
- Stream tagging and wrap: alternate send and stream for 10 words while popping continuously. Required: out_stream follows the alternating pattern, pointer wrap preserves order, and out_count ≤ 1 throughout.
- Async reset: assert reset low mid-cycle with 3 entries queued and an ack high. Required: immediately out_count = 0, out_valid = 0, all acks = 0 and inc_valid = 0, without waiting for a clock edge.

Source files
------------

// File: rtl/uarc_receiver.sv
// rtl/uarc_receiver.sv - receiver endpoint for one UARC bus lane
//
// Accepts kill/incept/send/stream requests from a sender lane, acknowledges each
// with a single-cycle registered pulse, and buffers send/stream words in a FIFO.
//
// Ports:
//   clk, reset (async active-low)
//   enable                 sender has selected this lane
//   kill/kill_ack          kill request / acknowledge pulse
//   incept/incept_ack      incept request / acknowledge pulse
//   send/send_ack          send request / acknowledge pulse
//   stream/stream_ack      stream request / acknowledge pulse
//   data                   send/stream word
//   self_permission, self_address, incept_permission, incept_address  incept payload
//   out_valid/out_ready    FIFO head valid / core pops head
//   out_data, out_stream   FIFO head word and its stream tag
//   out_count              FIFO occupancy
//   killed                 one-cycle pulse when a kill is accepted
//   inc_valid/inc_ready    latched incept payload held / consumed by core
//   inc_self_permission, inc_self_address, inc_permission, inc_address  latched payload
module uarc_receiver #(
  parameter int WORD_MAG = 5,
  parameter int FIFO_MAG = 2,
  localparam int WORD_WIDTH = 1 << WORD_MAG,
  localparam int FIFO_DEPTH = 1 << FIFO_MAG,
  localparam int PTR_W = (FIFO_MAG < 1) ? 1 : FIFO_MAG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  kill,
  output logic                  kill_ack,
  input  logic                  incept,
  output logic                  incept_ack,
  input  logic                  send,
  output logic                  send_ack,
  input  logic                  stream,
  output logic                  stream_ack,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic [WORD_WIDTH-1:0] self_permission,
  input  logic [WORD_WIDTH-1:0] self_address,
  input  logic [WORD_WIDTH-1:0] incept_permission,
  input  logic [WORD_WIDTH-1:0] incept_address,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_stream,
  output logic [FIFO_MAG:0]     out_count,
  output logic                  killed,
  output logic                  inc_valid,
  input  logic                  inc_ready,
  output logic [WORD_WIDTH-1:0] inc_self_permission,
  output logic [WORD_WIDTH-1:0] inc_self_address,
  output logic [WORD_WIDTH-1:0] inc_permission,
  output logic [WORD_WIDTH-1:0] inc_address
);

  // Each entry carries the stream tag above the data word.
  logic [WORD_WIDTH:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rptr;
  logic [PTR_W-1:0]    wptr;

  logic guard;
  logic eval;
  logic full;
  logic pop;
  logic can_push;
  logic do_kill;
  logic do_incept;
  logic do_send;
  logic do_stream;
  logic do_push;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Any ack high blocks evaluation so the sender has a cycle to change its request.
  assign guard     = kill_ack | incept_ack | send_ack | stream_ack;
  assign eval      = enable & ~guard;
  assign full      = (out_count == (FIFO_MAG+1)'(FIFO_DEPTH));
  assign out_valid = (out_count != '0);

  // Strict priority on the raw requests: a stalled higher-priority request
  // keeps lower ones pending rather than letting them overtake it.
  assign do_kill   = eval & kill;
  assign do_incept = eval & ~kill & incept & ~inc_valid;
  assign pop       = out_ready & out_valid & ~do_kill;
  assign can_push  = ~full | pop;
  assign do_send   = eval & ~kill & ~incept & send & can_push;
  assign do_stream = eval & ~kill & ~incept & ~send & stream & can_push;
  assign do_push   = do_send | do_stream;

  assign out_data   = mem[rptr][WORD_WIDTH-1:0];
  assign out_stream = mem[rptr][WORD_WIDTH];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {do_stream, data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill_ack            <= 1'b0;
      incept_ack          <= 1'b0;
      send_ack            <= 1'b0;
      stream_ack          <= 1'b0;
      killed              <= 1'b0;
      inc_valid           <= 1'b0;
      inc_self_permission <= '0;
      inc_self_address    <= '0;
      inc_permission      <= '0;
      inc_address         <= '0;
      rptr                <= '0;
      wptr                <= '0;
      out_count           <= '0;
    end else begin
      kill_ack   <= do_kill;
      incept_ack <= do_incept;
      send_ack   <= do_send;
      stream_ack <= do_stream;
      killed     <= do_kill;

      if (do_kill) begin
        inc_valid <= 1'b0;
      end else if (do_incept) begin
        inc_valid           <= 1'b1;
        inc_self_permission <= self_permission;
        inc_self_address    <= self_address;
        inc_permission      <= incept_permission;
        inc_address         <= incept_address;
      end else if (inc_valid && inc_ready) begin
        inc_valid <= 1'b0;
      end

      if (do_kill) begin
        rptr      <= '0;
        wptr      <= '0;
        out_count <= '0;
      end else begin
        if (pop)     rptr <= ptr_next(rptr);
        if (do_push) wptr <= ptr_next(wptr);
        case ({do_push, pop})
          2'b10:   out_count <= out_count + (FIFO_MAG+1)'(1);
          2'b01:   out_count <= out_count - (FIFO_MAG+1)'(1);
          default: out_count <= out_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uarc_receiver.sv
// tb/tb_uarc_receiver.sv - self-checking bench for uarc_receiver
module tb_uarc_receiver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, kill, incept, send, stream;
  logic        kill_ack, incept_ack, send_ack, stream_ack;
  logic [31:0] data, self_permission, self_address, incept_permission, incept_address;
  logic        out_valid, out_ready, out_stream, killed, inc_valid, inc_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic [31:0] inc_self_permission, inc_self_address, inc_permission, inc_address;

  int checks = 0;
  int failures = 0;

  uarc_receiver #(.WORD_MAG(5), .FIFO_MAG(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .kill(kill), .kill_ack(kill_ack), .incept(incept), .incept_ack(incept_ack),
    .send(send), .send_ack(send_ack), .stream(stream), .stream_ack(stream_ack),
    .data(data), .self_permission(self_permission), .self_address(self_address),
    .incept_permission(incept_permission), .incept_address(incept_address),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_stream(out_stream), .out_count(out_count), .killed(killed),
    .inc_valid(inc_valid), .inc_ready(inc_ready),
    .inc_self_permission(inc_self_permission), .inc_self_address(inc_self_address),
    .inc_permission(inc_permission), .inc_address(inc_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of {stream_tag, word}, the ack issued last cycle,
  // and the held incept payload.
  logic [32:0] q[$];
  logic [3:0]  m_acks;
  logic        m_killed;
  logic        m_inc_valid;
  logic [31:0] m_pay[4];

  task automatic model_reset();
    q.delete();
    m_acks = 4'b0;
    m_killed = 1'b0;
    m_inc_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_pay[i] = '0;
  endtask

  task automatic model_step();
    bit popped, pushed, nv;
    logic [3:0] nacks;
    logic [32:0] entry;
    popped = out_ready && (q.size() > 0);
    pushed = 0;
    nacks = 4'b0;
    m_killed = 1'b0;
    nv = m_inc_valid && !inc_ready;
    entry = '0;
    if (enable && m_acks == 4'b0) begin
      if (kill) begin
        nacks = 4'b1000; m_killed = 1'b1; q.delete(); popped = 0; nv = 0;
      end else if (incept) begin
        if (!m_inc_valid) begin
          nacks = 4'b0100; nv = 1;
          m_pay[0] = self_permission; m_pay[1] = self_address;
          m_pay[2] = incept_permission; m_pay[3] = incept_address;
        end
      end else if (send || stream) begin
        if (q.size() < DEPTH || popped) begin
          pushed = 1;
          entry = {!send, data};
          nacks = send ? 4'b0010 : 4'b0001;
        end
      end
    end
    if (popped) void'(q.pop_front());
    if (pushed) q.push_back(entry);
    m_acks = nacks;
    m_inc_valid = nv;
  endtask

  task automatic compare();
    chk("acks", {kill_ack, incept_ack, send_ack, stream_ack}, m_acks);
    chk("killed", killed, m_killed);
    chk("out_count", out_count, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("inc_valid", inc_valid, m_inc_valid);
    if (q.size() != 0) chk("fifo_head", {out_stream, out_data}, q[0]);
    if (m_inc_valid)
      chk("inc_payload", {inc_self_permission, inc_self_address, inc_permission, inc_address},
          {m_pay[0], m_pay[1], m_pay[2], m_pay[3]});
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enable = 0; kill = 0; incept = 0; send = 0; stream = 0; data = '0;
    self_permission = '0; self_address = '0; incept_permission = '0; incept_address = '0;
    out_ready = 0; inc_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        kill, incept, send, stream;
    logic [31:0] data;
    logic [3:0]  e_acks;
    logic        e_killed;
    logic [2:0]  e_count;
    logic        e_inc_valid;
    logic        e_chk;
    logic [31:0] e_data;
    logic        e_stream;
  } vec_t;

  vec_t vt[8];
  int   acks_seen;

  initial begin
    // Basic send then priority: outputs listed are those visible during the row.
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0010, 1'b0, 3'd1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h5,        4'b0000, 1'b0, 3'd1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h5,        4'b1000, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h5,        4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0100, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 1'b0};

    do_reset();
    enable = 1;
    for (int i = 0; i < 8; i++) begin
      kill = vt[i].kill; incept = vt[i].incept; send = vt[i].send;
      stream = vt[i].stream; data = vt[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_acks", i), {kill_ack, incept_ack, send_ack, stream_ack}, vt[i].e_acks);
      chk($sformatf("vec%0d_killed", i), killed, vt[i].e_killed);
      chk($sformatf("vec%0d_count", i), out_count, vt[i].e_count);
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_count != 0);
      chk($sformatf("vec%0d_inc_valid", i), inc_valid, vt[i].e_inc_valid);
      if (vt[i].e_chk) chk($sformatf("vec%0d_head", i), {out_stream, out_data}, {vt[i].e_stream, vt[i].e_data});
      @(posedge clk);
      #1;
    end

    // Fill and back-pressure.
    do_reset();
    enable = 1;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      send = 1; data = i; cycle();
      acks_seen += send_ack;
      send = 0; cycle();
    end
    chk("fill_acks", acks_seen, 4);
    chk("fill_count", out_count, 4);
    send = 1; data = 4;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin cycle(); acks_seen += send_ack; end
    chk("full_no_ack", acks_seen, 0);
    out_ready = 1; cycle();
    chk("pop_push_ack", send_ack, 1);
    chk("pop_push_count", out_count, 4);
    out_ready = 0; send = 0; cycle();
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("order%0d", k), out_data, k);
      cycle();
    end
    out_ready = 0; cycle();

    // Incept stall.
    do_reset();
    enable = 1;
    incept = 1;
    self_permission = 32'h11; self_address = 32'h22; incept_permission = 32'h33; incept_address = 32'h44;
    cycle();
    incept = 0; cycle();
    chk("inc_first", {inc_self_permission, inc_self_address, inc_permission, inc_address},
        {32'h11, 32'h22, 32'h33, 32'h44});
    incept = 1;
    self_permission = 32'h55; self_address = 32'h66; incept_permission = 32'h77; incept_address = 32'h88;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin cycle(); acks_seen += incept_ack; end
    chk("inc_stall", acks_seen, 0);
    inc_ready = 1; cycle();
    inc_ready = 0; cycle();
    chk("inc_second_ack", incept_ack, 1);
    chk("inc_second", inc_self_permission, 32'h55);
    incept = 0; cycle(); cycle();

    // Stream tagging with pointer wrap under continuous popping.
    do_reset();
    enable = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      send = (i % 2 == 0); stream = (i % 2 == 1); data = 32'h100 + i;
      cycle();
      chk($sformatf("tag%0d", i), {out_valid, out_stream, out_data}, {1'b1, (i % 2 == 1), 32'h100 + i});
      chk($sformatf("tag%0d_count_le1", i), out_count <= 1, 1);
      send = 0; stream = 0;
      cycle();
      chk($sformatf("drain%0d_count_le1", i), out_count <= 1, 1);
    end

    // Asynchronous reset with entries queued, an ack high and a payload held.
    do_reset();
    enable = 1;
    incept = 1; cycle(); incept = 0; cycle();
    for (int i = 0; i < 3; i++) begin
      send = 1; data = 32'hA0 + i; cycle();
      if (i < 2) begin send = 0; cycle(); end
    end
    chk("pre_reset_count", out_count, 3);
    chk("pre_reset_ack", send_ack, 1);
    send = 0;
    #2 reset = 0;
    #1;
    chk("async_count", out_count, 0);
    chk("async_valid", out_valid, 0);
    chk("async_acks", {kill_ack, incept_ack, send_ack, stream_ack}, 4'b0);
    chk("async_inc_valid", inc_valid, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      kill = ($urandom_range(0, 19) == 0);
      incept = ($urandom_range(0, 5) == 0);
      send = $urandom_range(0, 1);
      stream = $urandom_range(0, 1);
      data = $urandom;
      self_permission = $urandom; self_address = $urandom;
      incept_permission = $urandom; incept_address = $urandom;
      out_ready = ($urandom_range(0, 2) == 0);
      inc_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
